wb_arbiter_rr: RTL and testbench
================================

// Module: wb_arbiter_rr
// PURPOSE
//   Round-robin Wishbone B4 classic arbiter: shares one slave port (e.g. the
//   register slave) among N_MASTERS masters. Grant is held for a whole bus
//   cycle (CYC asserted) and muxes the granted master's signals to the slave.
//   Sits between master interfaces and a single slave on the system bus.
// PARAMETERS
//   N_MASTERS      4    number of requesting masters (2..8)
//   ADDR_WIDTH     16   address width
//   DATA_WIDTH     32   data width
//   GRANULE        8    select granularity; SEL_WIDTH = DATA_WIDTH/GRANULE
//   TIMEOUT_CYCLES 255  watchdog limit (only with WB_ARBITER_TIMEOUT_EN)
// PORTS
//   clk_i     in   1                     clock
//   rst_i     in   1                     synchronous reset, active-high
//   m_cyc_i   in   N_MASTERS             per-master CYC
//   m_stb_i   in   N_MASTERS             per-master STB
//   m_we_i    in   N_MASTERS             per-master WE
//   m_adr_i   in   N_MASTERS*ADDR_WIDTH  master k at [k*ADDR_WIDTH+:ADDR_WIDTH]
//   m_dat_i   in   N_MASTERS*DATA_WIDTH  master write data, same packing
//   m_sel_i   in   N_MASTERS*SEL_WIDTH   master SEL, same packing
//   m_dat_o   out  DATA_WIDTH            read data, broadcast to all masters
//   m_ack_o   out  N_MASTERS             per-master ACK
//   m_err_o   out  N_MASTERS             per-master ERR (0 unless timeout enabled)
//   s_cyc_o   out  1                     slave CYC
//   s_stb_o   out  1                     slave STB
//   s_we_o    out  1                     slave WE
//   s_adr_o   out  ADDR_WIDTH            slave address
//   s_dat_o   out  DATA_WIDTH            slave write data
//   s_sel_o   out  SEL_WIDTH             slave SEL
//   s_dat_i   in   DATA_WIDTH            slave read data
//   s_ack_i   in   1                     slave ACK
//   grant_o   out  N_MASTERS             one-hot current grant (0 when idle)
// BEHAVIOUR
// - Reset (rst_i at clk_i edge): state=IDLE, grant_o=0, last=N_MASTERS-1
//   (master 0 has top priority first), counter=0. Combinationally this gives
//   s_cyc_o=s_stb_o=0, m_ack_o=m_err_o=0. Reset mid-cycle: grant drops on the
//   edge, s_cyc_o low next cycle; no ACK is forwarded after reset.
// - States: IDLE, GRANTED, RELEASE.
//   IDLE: if any m_cyc_i, grant first k with m_cyc_i[k]=1 scanning
//     last+1, last+2, ... mod N_MASTERS; go GRANTED. Else stay.
//   GRANTED: while m_cyc_i[g]=1 stay. When m_cyc_i[g]=0: last<=g, grant<=0,
//     go IDLE (one dead cycle between owners; no back-to-back grants).
//   RELEASE (timeout only): grant kept for routing ERR, s_cyc_o forced 0;
//     when m_cyc_i[g]=0 -> last<=g, grant<=0, IDLE.
// - Latency: m_cyc_i rise in IDLE -> s_cyc_o high 1 cycle later.
// - Datapath (combinational from registered grant): s_cyc_o=m_cyc_i[g],
//   s_stb_o=m_stb_i[g]&m_cyc_i[g], s_we/adr/dat/sel = master g fields;
//   all s_* 0 when no grant. m_ack_o[g]=s_ack_i&s_stb_o; others 0.
//   m_dat_o=s_dat_i always (masters qualify with own ACK).
// - Non-granted masters see no ACK and wait; requests change nothing in GRANTED.
// - Single requester repeatedly: re-granted after each dead cycle.
// - s_ack_i while no grant: ignored.
// CONFIGURATION
//   WB_ARBITER_TIMEOUT_EN defined: counter cleared on grant and on every
//   s_ack_i; increments each GRANTED cycle with s_stb_o=1 and s_ack_i=0.
//   On reaching TIMEOUT_CYCLES: m_err_o[g]=1 for exactly one cycle, enter
//   RELEASE. Counter width $clog2(TIMEOUT_CYCLES+1).
//   Not defined: no counter, no RELEASE state, m_err_o tied 0.
// TESTING
// - Reset, m_cyc_i=0001 -> grant_o=0001 one cycle later; write 0xDEADBEEF
//   sel=1111 forwarded, m_ack_o=0001 with s_ack_i.
// - m_cyc_i=1111 held, each master drops CYC after one ACK -> grant order
//   0001,0010,0100,1000,0001 with one idle cycle between grants.
// - Master 2 granted, master 0 requests -> master 0 gets no ACK/grant until
//   master 2 drops CYC; then grant_o=0001 two cycles later (IDLE, then grant).
// - rst_i pulsed while granted with STB high -> s_cyc_o=0 next cycle,
//   grant_o=0, last=N-1; afterwards m_cyc_i=0110 grants master 1.
// - TIMEOUT_EN, TIMEOUT_CYCLES=4, slave never ACKs -> m_err_o[g]=1 on 4th
//   stalled cycle for one cycle, s_cyc_o=0 until master drops CYC.
// - Without TIMEOUT_EN, same stall -> grant held indefinitely, m_err_o=0.

Source files
------------

// File: rtl/wb_arbiter_rr_if.sv
// Bus bundle between the masters, the round-robin arbiter and the shared slave.
// The slave modport is the arbiter's view. The master modport is the surrounding environment's view.
interface wb_arbiter_rr_if #(
    parameter int N_MASTERS  = 4,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int SEL_WIDTH  = 4
);
    logic [N_MASTERS-1:0]            m_cyc_i;
    logic [N_MASTERS-1:0]            m_stb_i;
    logic [N_MASTERS-1:0]            m_we_i;
    logic [N_MASTERS*ADDR_WIDTH-1:0] m_adr_i;
    logic [N_MASTERS*DATA_WIDTH-1:0] m_dat_i;
    logic [N_MASTERS*SEL_WIDTH-1:0]  m_sel_i;
    logic [DATA_WIDTH-1:0]           m_dat_o;
    logic [N_MASTERS-1:0]            m_ack_o;
    logic [N_MASTERS-1:0]            m_err_o;
    logic                            s_cyc_o;
    logic                            s_stb_o;
    logic                            s_we_o;
    logic [ADDR_WIDTH-1:0]           s_adr_o;
    logic [DATA_WIDTH-1:0]           s_dat_o;
    logic [SEL_WIDTH-1:0]            s_sel_o;
    logic [DATA_WIDTH-1:0]           s_dat_i;
    logic                            s_ack_i;

    modport slave (
        input  m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i, s_dat_i, s_ack_i,
        output m_dat_o, m_ack_o, m_err_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o
    );

    modport master (
        output m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i, s_dat_i, s_ack_i,
        input  m_dat_o, m_ack_o, m_err_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o
    );
endinterface

// File: rtl/wb_arbiter_rr.sv
// Round-robin Wishbone B4 classic arbiter: N masters share one slave, and a grant lasts for the whole CYC.
// Define WB_ARBITER_TIMEOUT_EN to add a stall watchdog that reports ERR and then forces the slave cycle off.
//
//  state   | meaning
//  IDLE    | no owner; pick the next requester after the last owner
//  GRANTED | owner's signals routed to the slave until it drops CYC
//  RELEASE | watchdog fired; slave CYC forced low until owner drops CYC
module wb_arbiter_rr #(
    parameter int N_MASTERS      = 4,
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int GRANULE        = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    wb_arbiter_rr_if.slave       bus,
    output logic [N_MASTERS-1:0] grant_o
);
    localparam int SEL_WIDTH = DATA_WIDTH / GRANULE;
    localparam int IW        = $clog2(N_MASTERS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANTED = 2'd1
`ifdef WB_ARBITER_TIMEOUT_EN
        ,
        RELEASE = 2'd2
`endif
    } state_t;

    state_t               state_q, state_d;
    logic [N_MASTERS-1:0] grant_q, grant_d;
    logic [IW-1:0]        last_q, last_d;
    logic [IW-1:0]        gidx;
    logic                 gvalid;
    logic                 cyc_g;
    logic                 stb_g;
    logic                 release_act;
    logic                 err_hit;

`ifdef WB_ARBITER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
    logic [CW-1:0] cnt_q, cnt_d;
`endif

    always_comb begin
        gidx = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (grant_q[i]) gidx = IW'(i);
        end
    end

    assign gvalid = |grant_q;
    assign cyc_g  = gvalid & bus.m_cyc_i[gidx];
    assign stb_g  = cyc_g & bus.m_stb_i[gidx];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= IW'(N_MASTERS - 1);
`ifdef WB_ARBITER_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
`ifdef WB_ARBITER_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        err_hit     = 1'b0;
        release_act = 1'b0;
`ifdef WB_ARBITER_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                logic found;
                int   k;
                found = 1'b0;
                // Scan starts just after the previous owner so every requester gets a turn.
                for (int i = 1; i <= N_MASTERS; i++) begin
                    k = int'(last_q) + i;
                    if (k >= N_MASTERS) k = k - N_MASTERS;
                    if (!found && bus.m_cyc_i[k[IW-1:0]]) begin
                        found                = 1'b1;
                        grant_d              = '0;
                        grant_d[k[IW-1:0]]   = 1'b1;
                    end
                end
                if (found) state_d = GRANTED;
`ifdef WB_ARBITER_TIMEOUT_EN
                cnt_d = '0;
`endif
            end
            GRANTED: begin
                if (!cyc_g) begin
                    last_d  = gidx;
                    grant_d = '0;
                    state_d = IDLE;
                end
`ifdef WB_ARBITER_TIMEOUT_EN
                else if (bus.s_ack_i) begin
                    cnt_d = '0;
                end else if (stb_g) begin
                    if (cnt_q == CNT_LAST) begin
                        err_hit = 1'b1;
                        state_d = RELEASE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
`endif
            end
`ifdef WB_ARBITER_TIMEOUT_EN
            RELEASE: begin
                release_act = 1'b1;
                if (bus.s_ack_i) cnt_d = '0;
                if (!cyc_g) begin
                    last_d  = gidx;
                    grant_d = '0;
                    state_d = IDLE;
                end
            end
`endif
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_comb begin
        bus.s_cyc_o = cyc_g & ~release_act;
        bus.s_stb_o = stb_g & ~release_act;
        bus.s_we_o  = 1'b0;
        bus.s_adr_o = '0;
        bus.s_dat_o = '0;
        bus.s_sel_o = '0;
        if (gvalid) begin
            bus.s_we_o  = bus.m_we_i[gidx];
            bus.s_adr_o = bus.m_adr_i[gidx*ADDR_WIDTH +: ADDR_WIDTH];
            bus.s_dat_o = bus.m_dat_i[gidx*DATA_WIDTH +: DATA_WIDTH];
            bus.s_sel_o = bus.m_sel_i[gidx*SEL_WIDTH +: SEL_WIDTH];
        end
    end

    always_comb begin
        bus.m_ack_o = '0;
        if (bus.s_stb_o && bus.s_ack_i) bus.m_ack_o[gidx] = 1'b1;
    end

`ifdef WB_ARBITER_TIMEOUT_EN
    always_comb begin
        bus.m_err_o = '0;
        if (err_hit) bus.m_err_o[gidx] = 1'b1;
    end
`else
    assign bus.m_err_o = '0;
`endif

    assign bus.m_dat_o = bus.s_dat_i;
    assign grant_o     = grant_q;
endmodule

// File: tb/tb_wb_arbiter_rr.sv
// Directed bench for wb_arbiter_rr: single grant, round-robin order, blocking of other masters, reset mid-cycle and slave stall.
module tb_wb_arbiter_rr;
    localparam int N  = 4;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int SW = 4;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic [N-1:0] grant_o;
    int           n_chk  = 0;
    int           n_fail = 0;

    wb_arbiter_rr_if #(.N_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SEL_WIDTH(SW)) bus ();

    wb_arbiter_rr #(
        .N_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .GRANULE(8), .TIMEOUT_CYCLES(4)
    ) dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .bus    (bus),
        .grant_o(grant_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_m(input int k, input logic cyc, input logic stb, input logic we,
                         input logic [AW-1:0] adr, input logic [DW-1:0] dat, input logic [SW-1:0] sel);
        bus.m_cyc_i[k]         = cyc;
        bus.m_stb_i[k]         = stb;
        bus.m_we_i[k]          = we;
        bus.m_adr_i[k*AW +: AW] = adr;
        bus.m_dat_i[k*DW +: DW] = dat;
        bus.m_sel_i[k*SW +: SW] = sel;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        bus.m_cyc_i = '0;
        bus.m_stb_i = '0;
        bus.m_we_i  = '0;
        bus.m_adr_i = '0;
        bus.m_dat_i = '0;
        bus.m_sel_i = '0;
        bus.s_ack_i = 1'b0;
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    initial begin
        int order [5];
        int k;
        order = '{0, 1, 2, 3, 0};
        bus.s_dat_i = 32'hCAFEF00D;

        // Reset state
        do_reset();
        #1;
        chk("rst_grant", 64'(grant_o), 64'h0);
        chk("rst_scyc", 64'(bus.s_cyc_o), 64'h0);
        chk("rst_sstb", 64'(bus.s_stb_o), 64'h0);
        chk("rst_ack", 64'(bus.m_ack_o), 64'h0);
        chk("rst_err", 64'(bus.m_err_o), 64'h0);

        // Single write from master 0
        set_m(0, 1, 1, 1, 16'h1234, 32'hDEADBEEF, 4'hF);
        #1;
        chk("t1_idle_grant", 64'(grant_o), 64'h0);
        chk("t1_idle_scyc", 64'(bus.s_cyc_o), 64'h0);
        tick();
        chk("t1_grant", 64'(grant_o), 64'h1);
        chk("t1_scyc", 64'(bus.s_cyc_o), 64'h1);
        chk("t1_sstb", 64'(bus.s_stb_o), 64'h1);
        chk("t1_swe", 64'(bus.s_we_o), 64'h1);
        chk("t1_sadr", 64'(bus.s_adr_o), 64'h1234);
        chk("t1_sdat", 64'(bus.s_dat_o), 64'hDEADBEEF);
        chk("t1_ssel", 64'(bus.s_sel_o), 64'hF);
        chk("t1_mdat", 64'(bus.m_dat_o), 64'hCAFEF00D);
        bus.s_ack_i = 1'b1;
        #1;
        chk("t1_ack", 64'(bus.m_ack_o), 64'h1);
        tick();
        bus.s_ack_i = 1'b0;
        set_m(0, 0, 0, 0, '0, '0, '0);
        tick();
        chk("t1_release", 64'(grant_o), 64'h0);

        // Round robin with all four requesting
        do_reset();
        for (int m = 0; m < N; m++) set_m(m, 1, 1, 0, AW'(16'h0100 * m + 16'h10), DW'(m), 4'h1);
        #1;
        chk("rr_start_grant", 64'(grant_o), 64'h0);
        for (int j = 0; j < 5; j++) begin
            k = order[j];
            tick();
            chk($sformatf("rr%0d_grant", j), 64'(grant_o), 64'(1 << k));
            chk($sformatf("rr%0d_sadr", j), 64'(bus.s_adr_o), 64'(16'h0100 * k + 16'h10));
            bus.s_ack_i = 1'b1;
            #1;
            chk($sformatf("rr%0d_ack", j), 64'(bus.m_ack_o), 64'(1 << k));
            tick();
            bus.s_ack_i = 1'b0;
            set_m(k, 0, 0, 0, AW'(16'h0100 * k + 16'h10), DW'(k), 4'h1);
            #1;
            chk($sformatf("rr%0d_scyc_drop", j), 64'(bus.s_cyc_o), 64'h0);
            tick();
            chk($sformatf("rr%0d_dead", j), 64'(grant_o), 64'h0);
            set_m(k, 1, 1, 0, AW'(16'h0100 * k + 16'h10), DW'(k), 4'h1);
        end

        // Master 2 owns the bus while master 0 waits
        do_reset();
        set_m(2, 1, 1, 0, 16'h0222, 32'h2, 4'h3);
        tick();
        chk("blk_grant2", 64'(grant_o), 64'h4);
        set_m(0, 1, 1, 1, 16'h0000, 32'h0, 4'hF);
        bus.s_ack_i = 1'b1;
        #1;
        chk("blk_ack2only", 64'(bus.m_ack_o), 64'h4);
        tick();
        chk("blk_hold1", 64'(grant_o), 64'h4);
        tick();
        chk("blk_hold2", 64'(grant_o), 64'h4);
        bus.s_ack_i = 1'b0;
        set_m(2, 0, 0, 0, '0, '0, '0);
        tick();
        chk("blk_dead", 64'(grant_o), 64'h0);
        tick();
        chk("blk_grant0", 64'(grant_o), 64'h1);
        chk("blk_sadr0", 64'(bus.s_adr_o), 64'h0);

        // Reset while master 0 is mid-cycle
        rst_i = 1'b1;
        tick();
        chk("mid_rst_grant", 64'(grant_o), 64'h0);
        chk("mid_rst_scyc", 64'(bus.s_cyc_o), 64'h0);
        bus.s_ack_i = 1'b1;
        #1;
        chk("mid_rst_ack", 64'(bus.m_ack_o), 64'h0);
        rst_i = 1'b0;
        bus.s_ack_i = 1'b0;
        set_m(0, 0, 0, 0, '0, '0, '0);
        set_m(1, 1, 1, 0, 16'h0111, 32'h1, 4'h1);
        set_m(2, 1, 1, 0, 16'h0222, 32'h2, 4'h1);
        tick();
        chk("mid_rst_grant1", 64'(grant_o), 64'h2);
        set_m(1, 0, 0, 0, '0, '0, '0);
        tick();
        chk("mid_dead", 64'(grant_o), 64'h0);
        tick();
        chk("mid_grant2", 64'(grant_o), 64'h4);
        set_m(2, 0, 0, 0, '0, '0, '0);
        tick();
        chk("idle_grant", 64'(grant_o), 64'h0);
        bus.s_ack_i = 1'b1;
        #1;
        chk("idle_ack_ignored", 64'(bus.m_ack_o), 64'h0);
        bus.s_ack_i = 1'b0;

        // Slave never acknowledges master 3
        set_m(3, 1, 1, 0, 16'h0333, 32'h3, 4'hF);
        tick();
        chk("stall_grant", 64'(grant_o), 64'h8);
        for (int c = 1; c <= 4; c++) begin
`ifdef WB_ARBITER_TIMEOUT_EN
            chk($sformatf("stall%0d_err", c), 64'(bus.m_err_o), (c == 4) ? 64'h8 : 64'h0);
`else
            chk($sformatf("stall%0d_err", c), 64'(bus.m_err_o), 64'h0);
`endif
            chk($sformatf("stall%0d_scyc", c), 64'(bus.s_cyc_o), 64'h1);
            tick();
        end
        for (int c = 5; c <= 6; c++) begin
            chk($sformatf("stall%0d_err", c), 64'(bus.m_err_o), 64'h0);
            chk($sformatf("stall%0d_grant", c), 64'(grant_o), 64'h8);
`ifdef WB_ARBITER_TIMEOUT_EN
            chk($sformatf("stall%0d_scyc", c), 64'(bus.s_cyc_o), 64'h0);
`else
            chk($sformatf("stall%0d_scyc", c), 64'(bus.s_cyc_o), 64'h1);
`endif
            tick();
        end
        set_m(3, 0, 0, 0, '0, '0, '0);
        tick();
        chk("stall_end_grant", 64'(grant_o), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
